// File: rtl/tft_pkg.sv
// tft_pkg: shared line-fetch geometry and fetch FSM state encoding
package tft_pkg;
  localparam int H_WORDS = 320;
  localparam int V_LINES = 1024;
  localparam int BURST_LEN = 16;
  localparam int LINE_BYTES = 5120;
  localparam int ADDR_W = 32;
  localparam int WORD_W = 128;
  localparam int LINE_W = 10;
  localparam int N_BURSTS = H_WORDS / BURST_LEN;
  localparam int BURST_BYTES = BURST_LEN * 16;
  localparam int BURST_W = $clog2(N_BURSTS);
  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
endpackage

// File: rtl/tft_line_fetch_if.sv
// tft_line_fetch_if: framebuffer burst-read bus between fetcher and memory
interface tft_line_fetch_if import tft_pkg::*; ();
  logic mem_rd_req;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic mem_rd_ack;
  logic [WORD_W-1:0] mem_rd_data;
  logic mem_rd_valid;
  modport master (output mem_rd_req, mem_rd_addr, input mem_rd_ack, mem_rd_data, mem_rd_valid);
  modport slave (input mem_rd_req, mem_rd_addr, output mem_rd_ack, mem_rd_data, mem_rd_valid);
endinterface

// File: rtl/tft_fetch_addr_gen.sv
// tft_fetch_addr_gen: registered burst start address from base, line and burst index
module tft_fetch_addr_gen import tft_pkg::*; (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic [ADDR_W-1:0] fb_base_lat,
  input  logic [LINE_W-1:0] line_num,
  input  logic [BURST_W-1:0] burst_idx,
  output logic [ADDR_W-1:0] mem_rd_addr
);
  // inputs are next-state values so the address lands together with the state that uses it
  always_ff @(posedge sys_clk)
    mem_rd_addr <= sys_rst ? '0 : fb_base_lat + ADDR_W'(line_num) * ADDR_W'(LINE_BYTES)
                                + ADDR_W'(burst_idx) * ADDR_W'(BURST_BYTES);
endmodule

// File: rtl/tft_line_fetch.sv
// tft_line_fetch: fetches one display line per line_req in bursts and streams it to the line buffer
module tft_line_fetch import tft_pkg::*; #(
  parameter int FRAME_LINES = V_LINES
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic frame_start,
  input  logic line_req,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic err_clr,
  tft_line_fetch_if.master mem,
  output logic [WORD_W-1:0] PLB_BRAM_data,
  output logic PLB_BRAM_we,
  output logic busy,
  output logic [LINE_W-1:0] line_num,
  output logic err_overrun,
  output logic err_stray
);
  logic [1:0] state, state_nxt;
  logic [ADDR_W-1:0] base_lat, base_nxt, pend_base, pend_base_nxt;
  logic pend, pend_nxt;
  logic [LINE_W-1:0] line_nxt, line_inc;
  logic [BURST_W-1:0] burst, burst_nxt;
  logic [BEAT_W-1:0] beat, beat_nxt;
  logic take, beat_last, burst_last;
  assign take = mem.mem_rd_valid && state == ST_DATA;
  assign beat_last = beat == BEAT_W'(BURST_LEN - 1);
  assign burst_last = burst == BURST_W'(N_BURSTS - 1);
  assign line_inc = line_num == LINE_W'(FRAME_LINES - 1) ? '0 : line_num + LINE_W'(1);
  assign busy = state != ST_IDLE;
  assign mem.mem_rd_req = state == ST_REQ;
  tft_fetch_addr_gen u_addr (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .fb_base_lat(base_nxt),
    .line_num(line_nxt),
    .burst_idx(burst_nxt),
    .mem_rd_addr(mem.mem_rd_addr)
  );
  // fetch sequencing; a frame start seen while busy is parked and applied in DONE
  always_comb begin
    state_nxt = state;
    base_nxt = base_lat;
    pend_nxt = pend;
    pend_base_nxt = pend_base;
    line_nxt = line_num;
    burst_nxt = burst;
    beat_nxt = beat;
    case (state)
      ST_IDLE: begin
        base_nxt = frame_start ? fb_base : base_lat;
        line_nxt = frame_start ? '0 : line_num;
        if (line_req) begin
          state_nxt = ST_REQ;
          burst_nxt = '0;
          beat_nxt = '0;
        end
      end
      ST_REQ: begin
        state_nxt = mem.mem_rd_ack ? ST_DATA : ST_REQ;
        beat_nxt = '0;
      end
      ST_DATA: if (take) begin
        beat_nxt = beat + BEAT_W'(1);
        if (beat_last) begin
          state_nxt = burst_last ? ST_DONE : ST_REQ;
          burst_nxt = burst_last ? '0 : burst + BURST_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        pend_nxt = 1'b0;
        base_nxt = frame_start ? fb_base : pend ? pend_base : base_lat;
        line_nxt = (frame_start || pend) ? '0 : line_inc;
      end
    endcase
    if (frame_start && (state == ST_REQ || state == ST_DATA)) begin
      pend_nxt = 1'b1;
      pend_base_nxt = fb_base;
    end
  end
  // control state registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= ST_IDLE;
      base_lat <= '0;
      pend <= 1'b0;
      pend_base <= '0;
      line_num <= '0;
      burst <= '0;
      beat <= '0;
    end else begin
      state <= state_nxt;
      base_lat <= base_nxt;
      pend <= pend_nxt;
      pend_base <= pend_base_nxt;
      line_num <= line_nxt;
      burst <= burst_nxt;
      beat <= beat_nxt;
    end
  end
  // one-cycle data path to the line buffer; data holds between strobes
  always_ff @(posedge sys_clk) begin
    PLB_BRAM_we <= !sys_rst && take;
    PLB_BRAM_data <= sys_rst ? '0 : take ? mem.mem_rd_data : PLB_BRAM_data;
  end
  // sticky error flags; a new event beats a simultaneous clear
  always_ff @(posedge sys_clk) begin
    err_overrun <= sys_rst ? 1'b0 : (line_req && busy) ? 1'b1 : err_clr ? 1'b0 : err_overrun;
    err_stray <= sys_rst ? 1'b0 : (mem.mem_rd_valid && state != ST_DATA) ? 1'b1 : err_clr ? 1'b0 : err_stray;
  end
endmodule

// File: tb/tb_tft_line_fetch.sv
// tb_tft_line_fetch: directed bench for the line fetcher with a burst memory responder
module tb_tft_line_fetch;
  import tft_pkg::*;
  localparam int FL = 8;
  logic sys_clk = 0;
  logic sys_rst = 1;
  logic frame_start = 0;
  logic line_req = 0;
  logic err_clr = 0;
  logic [31:0] fb_base = '0;
  logic [127:0] PLB_BRAM_data;
  logic PLB_BRAM_we, busy, err_overrun, err_stray;
  logic [9:0] line_num;
  tft_line_fetch_if mem();
  tft_line_fetch #(.FRAME_LINES(FL)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .frame_start(frame_start),
    .line_req(line_req),
    .fb_base(fb_base),
    .err_clr(err_clr),
    .mem(mem),
    .PLB_BRAM_data(PLB_BRAM_data),
    .PLB_BRAM_we(PLB_BRAM_we),
    .busy(busy),
    .line_num(line_num),
    .err_overrun(err_overrun),
    .err_stray(err_stray)
  );
  always #5 sys_clk = ~sys_clk;
  int n_chk = 0, n_bad = 0, wr_cnt = 0, w0 = 0, r0 = 0;
  logic [31:0] req_q[$];
  logic gaps = 0, inject = 0, pend_good = 0, exp_we = 0;
  logic [127:0] pend_dat = '0, exp_dat = '0;
  int w = 0, beats = 0, m_beat = 0;
  logic [31:0] m_addr = '0;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask
  // memory: acks the second cycle of a request, then returns 16 beats, optionally gapped
  initial begin
    mem.mem_rd_ack = 0;
    mem.mem_rd_valid = 0;
    mem.mem_rd_data = '0;
    forever begin
      @(posedge sys_clk);
      #2;
      exp_we = pend_good;
      exp_dat = pend_dat;
      pend_good = 0;
      mem.mem_rd_ack = 0;
      mem.mem_rd_valid = 0;
      if (sys_rst) begin
        beats = 0;
        w = 0;
      end else if (inject) begin
        mem.mem_rd_valid = 1;
        mem.mem_rd_data = {4{32'hDEAD_BEEF}};
      end else if (beats > 0) begin
        if (!gaps || $urandom_range(0, 2) != 0) begin
          mem.mem_rd_data = {m_addr, 32'(m_beat), $urandom, $urandom};
          mem.mem_rd_valid = 1;
          pend_good = 1;
          pend_dat = mem.mem_rd_data;
          m_beat++;
          beats--;
        end
      end else if (mem.mem_rd_req) begin
        w++;
        if (w == 2) begin
          mem.mem_rd_ack = 1;
          req_q.push_back(mem.mem_rd_addr);
          m_addr = mem.mem_rd_addr;
          beats = 16;
          m_beat = 0;
          w = 0;
        end
      end
    end
  end
  // every strobe must match a beat returned exactly one cycle earlier, in order
  always @(negedge sys_clk)
    if (PLB_BRAM_we || exp_we) begin
      chk("we", PLB_BRAM_we, exp_we);
      if (exp_we) chk("wdata", PLB_BRAM_data, exp_dat);
      if (PLB_BRAM_we) wr_cnt++;
    end
  task automatic zero_chk();
    chk("z_we", PLB_BRAM_we, 0);
    chk("z_data", PLB_BRAM_data, 0);
    chk("z_busy", busy, 0);
    chk("z_req", mem.mem_rd_req, 0);
    chk("z_addr", mem.mem_rd_addr, 0);
    chk("z_line", line_num, 0);
    chk("z_ovr", err_overrun, 0);
    chk("z_stray", err_stray, 0);
  endtask
  task automatic start_line(input logic fs);
    w0 = wr_cnt;
    r0 = req_q.size();
    chk("busy_pre", busy, 0);
    line_req = 1;
    frame_start = fs;
    tick();
    line_req = 0;
    frame_start = 0;
    chk("busy_rise", busy, 1);
  endtask
  task automatic wait_wr(input int n);
    for (int i = 0; i < 2000 && wr_cnt - w0 < n; i++) tick();
    chk("wr_reach", wr_cnt - w0 >= n, 1);
  endtask
  task automatic finish_line(input logic [31:0] exp0, input logic [9:0] exp_line);
    for (int i = 0; i < 4000 && busy; i++) tick();
    chk("busy_fall", busy, 0);
    tick(2);
    chk("nreq", req_q.size() - r0, 20);
    for (int k = 0; k < 20 && r0 + k < req_q.size(); k++)
      chk("addr", req_q[r0+k], exp0 + 32'(k) * 32'h100);
    chk("nwr", wr_cnt - w0, 320);
    chk("line", line_num, exp_line);
  endtask
  initial begin
    tick(3);
    zero_chk();
    sys_rst = 0;
    tick();
    fb_base = 32'h1000_0000;
    frame_start = 1;
    tick();
    frame_start = 0;
    chk("fs_line", line_num, 0);
    start_line(0);
    finish_line(32'h1000_0000, 1);
    chk("ovr0", err_overrun, 0);
    chk("stray0", err_stray, 0);
    gaps = 1;
    start_line(0);
    finish_line(32'h1000_1400, 2);
    gaps = 0;
    start_line(0);
    wait_wr(100);
    line_req = 1;
    err_clr = 1;
    tick();
    line_req = 0;
    err_clr = 0;
    chk("ovr_set", err_overrun, 1);
    finish_line(32'h1000_2800, 3);
    r0 = req_q.size();
    tick(30);
    chk("no_extra", req_q.size() - r0, 0);
    chk("idle", busy, 0);
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("ovr_clr", err_overrun, 0);
    frame_start = 1;
    tick();
    frame_start = 0;
    chk("fs_line0", line_num, 0);
    for (int i = 0; i < FL; i++) begin
      start_line(0);
      finish_line(32'h1000_0000 + 32'(i) * 32'h1400, 10'((i + 1) % FL));
    end
    start_line(0);
    finish_line(32'h1000_0000, 1);
    start_line(0);
    wait_wr(50);
    fb_base = 32'h2000_0000;
    frame_start = 1;
    tick();
    frame_start = 0;
    fb_base = 32'h5000_0000;
    finish_line(32'h1000_1400, 0);
    start_line(0);
    finish_line(32'h2000_0000, 1);
    fb_base = 32'h3000_0000;
    start_line(1);
    finish_line(32'h3000_0000, 1);
    inject = 1;
    tick();
    inject = 0;
    tick(2);
    chk("stray_set", err_stray, 1);
    chk("stray_line", line_num, 1);
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("stray_clr", err_stray, 0);
    start_line(0);
    for (int i = 0; i < 2000 && req_q.size() - r0 < 8; i++) tick();
    tick(5);
    sys_rst = 1;
    tick();
    sys_rst = 0;
    zero_chk();
    start_line(0);
    finish_line(32'h0000_0000, 1);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
